// File: rtl/dvp_pkg.sv
// Shared definitions for the DVP write-channel arbiter: FSM encoding and
// command-word field positions.
package dvp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    localparam int unsigned DWR_DATA_W       = 32;
    localparam int unsigned DWR_ID_W         = 3;
    localparam int unsigned DWR_CNT_W        = 16;
    localparam int unsigned DWR_SIL_W        = 8;
    localparam int unsigned DWR_CMD_LAST_BIT = 9;
    localparam int unsigned DWR_CMD_LEN_MSB  = 7;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request searching upward
// from ptr+1, wrapping modulo NREQ.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   idx,
    output logic            vld
);

    always_comb begin
        int unsigned pos;
        idx = '0;
        vld = 1'b0;
        pos = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            pos = (32'(ptr) + k) % NREQ;
            if (!vld && req[IW'(pos)]) begin
                vld = 1'b1;
                idx = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/dwr_arb.sv
// Round-robin arbiter sharing the DDR write channel among NREQ burst writers;
// holds each grant for a whole burst and forwards beats with SOP/ID sideband.
module dwr_arb
    import dvp_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned TMO  = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enb,
    input  logic [NREQ-1:0]              req,
    output logic [NREQ-1:0]              ack,
    input  logic [NREQ-1:0]              vin,
    input  logic [DWR_DATA_W*NREQ-1:0]   din,
    output logic                         m_vout,
    output logic [DWR_DATA_W-1:0]        m_dout,
    output logic                         m_sop,
    output logic [DWR_ID_W-1:0]          m_id,
    output logic [NREQ-1:0]              frm_done,
    output logic                         tmo_err,
    output logic [DWR_CNT_W-1:0]         gnt_cnt
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam logic [DWR_SIL_W-1:0] TMO_CNT = DWR_SIL_W'(TMO);

    arb_state_e              state_q, state_d;
    logic [IW-1:0]           gnt_id_q, gnt_id_d;
    logic [IW-1:0]           ptr_q, ptr_d;
    logic [NREQ-1:0]         ack_q, ack_d;
    logic [DWR_SIL_W-1:0]    sil_q, sil_d;
    logic                    last_q, last_d;
    logic                    sop_pend_q, sop_pend_d;
    logic [NREQ-1:0]         frm_done_q, frm_done_d;
    logic                    tmo_err_q, tmo_err_d;
    logic [DWR_CNT_W-1:0]    gnt_cnt_q, gnt_cnt_d;

    logic [NREQ-1:0][DWR_DATA_W-1:0] din_a;
    logic [DWR_DATA_W-1:0]           din_g;
    logic                            vin_g;
    logic                            req_g;
    logic [IW-1:0]                   pick_idx;
    logic                            pick_vld;

    assign din_a = din;
    assign din_g = din_a[gnt_id_q];
    assign vin_g = vin[gnt_id_q];
    assign req_g = req[gnt_id_q];

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req (req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    // Zero-latency beat forwarding from the granted port
    assign m_vout   = vin_g & ack_q[gnt_id_q] & (state_q == ST_GRANT);
    assign m_dout   = m_vout ? din_g : '0;
    assign m_sop    = m_vout & sop_pend_q;
    assign m_id     = DWR_ID_W'(gnt_id_q);
    assign ack      = ack_q;
    assign frm_done = frm_done_q;
    assign tmo_err  = tmo_err_q;
    assign gnt_cnt  = gnt_cnt_q;

    always_comb begin
        state_d    = state_q;
        gnt_id_d   = gnt_id_q;
        ptr_d      = ptr_q;
        ack_d      = ack_q;
        sil_d      = sil_q;
        last_d     = last_q;
        sop_pend_d = sop_pend_q;
        tmo_err_d  = tmo_err_q;
        gnt_cnt_d  = gnt_cnt_q;
        frm_done_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (enb && pick_vld) begin
                    state_d    = ST_GRANT;
                    gnt_id_d   = pick_idx;
                    ack_d      = NREQ'(1) << pick_idx;
                    sil_d      = '0;
                    last_d     = 1'b0;
                    sop_pend_d = 1'b1;
                end
            end
            ST_GRANT: begin
                if (m_vout) begin
                    sil_d = '0;
                    if (sop_pend_q) begin
                        sop_pend_d = 1'b0;
                        last_d     = din_g[DWR_CMD_LAST_BIT];
                    end
                end else if (req_g) begin
                    sil_d = sil_q + 1'b1;
                end
                // Requester release wins over a coincident timeout
                if (!req_g) begin
                    ack_d                = '0;
                    state_d              = ST_RELEASE;
                    frm_done_d[gnt_id_q] = last_d;
                end else if (!m_vout && (sil_d == TMO_CNT)) begin
                    ack_d     = '0;
                    tmo_err_d = 1'b1;
                    state_d   = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                ptr_d     = gnt_id_q;
                gnt_cnt_d = gnt_cnt_q + 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_id_q   <= '0;
            ptr_q      <= IW'(NREQ - 1);
            ack_q      <= '0;
            sil_q      <= '0;
            last_q     <= 1'b0;
            sop_pend_q <= 1'b0;
            frm_done_q <= '0;
            tmo_err_q  <= 1'b0;
            gnt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            gnt_id_q   <= gnt_id_d;
            ptr_q      <= ptr_d;
            ack_q      <= ack_d;
            sil_q      <= sil_d;
            last_q     <= last_d;
            sop_pend_q <= sop_pend_d;
            frm_done_q <= frm_done_d;
            tmo_err_q  <= tmo_err_d;
            gnt_cnt_q  <= gnt_cnt_d;
        end
    end

endmodule

// File: tb/tb_dwr_arb.sv
// Randomized bench for dwr_arb: behavioural requesters plus a transaction-level
// arbitration model checked every cycle, with directed scenarios in between.
module tb_dwr_arb;

    localparam int NREQ = 4;
    localparam int TMO  = 255;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   enb;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        ack;
    logic [NREQ-1:0]        vin;
    logic [32*NREQ-1:0]     din;
    logic                   m_vout;
    logic [31:0]            m_dout;
    logic                   m_sop;
    logic [2:0]             m_id;
    logic [NREQ-1:0]        frm_done;
    logic                   tmo_err;
    logic [15:0]            gnt_cnt;

    always #5 clk = ~clk;

    dwr_arb #(.NREQ(NREQ), .TMO(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .enb      (enb),
        .req      (req),
        .ack      (ack),
        .vin      (vin),
        .din      (din),
        .m_vout   (m_vout),
        .m_dout   (m_dout),
        .m_sop    (m_sop),
        .m_id     (m_id),
        .frm_done (frm_done),
        .tmo_err  (tmo_err),
        .gnt_cnt  (gnt_cnt)
    );

    int n_chk;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: arbitration phase, owner, rotation pointer, burst facts
    int              mph;        // 0 idle, 1 granted, 2 releasing
    int              mg;
    int              mptr;
    int              msil;
    bit              mfirst;
    bit              mlast;
    bit              mtmo;
    int              mcnt;
    logic [NREQ-1:0] mfrm;

    logic [NREQ-1:0] s_req, s_vin;
    logic [31:0]     s_din [NREQ];
    bit              s_enb, s_rst;

    // Requester behaviour
    int          blen [NREQ];
    int          sent [NREQ];
    bit          silent [NREQ];
    bit          got [NREQ];
    logic [31:0] cmd [NREQ];
    int          pct [NREQ];
    int          sil_pct, enb_pct, blen_fix;
    bit          noise;

    // Observations of the DUT for directed scenarios
    int              dq[$];
    logic [NREQ-1:0] prev_ack;
    int              frm_seen [NREQ];
    int              ack_hi [NREQ];
    int              sop_seen, beat_seen;

    function automatic logic [31:0] port_din(input int i);
        return din[32*i +: 32];
    endfunction

    function automatic int qat(input int i);
        if (i >= 0 && i < dq.size()) return dq[i];
        return -1;
    endfunction

    task automatic model_reset();
        mph = 0; mg = 0; mptr = NREQ - 1; msil = 0;
        mfirst = 0; mlast = 0; mtmo = 0; mcnt = 0; mfrm = '0;
    endtask

    task automatic model_update();
        bit found;
        bit beat;
        if (s_rst) begin
            model_reset();
        end else begin
            mfrm = '0;
            case (mph)
                0: if (s_enb && s_req != '0) begin
                    found = 0;
                    for (int k = 1; k <= NREQ; k++) begin
                        int p;
                        p = (mptr + k) % NREQ;
                        if (!found && s_req[p]) begin
                            found = 1;
                            mg = p;
                        end
                    end
                    mph = 1; msil = 0; mfirst = 1; mlast = 0;
                end
                1: begin
                    beat = s_vin[mg];
                    if (beat) begin
                        msil = 0;
                        if (mfirst) begin
                            mlast  = s_din[mg][9];
                            mfirst = 0;
                        end
                    end
                    if (!s_req[mg]) begin
                        mph = 2;
                        mfrm[mg] = mlast;
                    end else if (!beat) begin
                        msil++;
                        if (msil == TMO) begin
                            mph = 2;
                            mtmo = 1;
                        end
                    end
                end
                default: begin
                    mptr = mg;
                    mcnt = (mcnt + 1) % 65536;
                    mph = 0;
                end
            endcase
        end
    endtask

    task automatic raise(input int i, input int len, input logic [31:0] c, input bit sil);
        req[i] = 1'b1; vin[i] = 1'b0;
        sent[i] = 0; blen[i] = len; cmd[i] = c; silent[i] = sil; got[i] = 0;
    endtask

    task automatic drive_inputs();
        enb = int'($urandom % 8) < enb_pct;
        for (int i = 0; i < NREQ; i++) begin
            if (!req[i]) begin
                if (pct[i] > 0 && int'($urandom % 16) < pct[i]) begin
                    raise(i, (blen_fix != 0) ? blen_fix : 1 + int'($urandom % 12),
                          $urandom, int'($urandom % 64) < sil_pct);
                end else begin
                    vin[i] = noise ? 1'($urandom) : 1'b0;
                    din[32*i +: 32] = $urandom;
                end
            end else if (ack[i]) begin
                got[i] = 1;
                if (sent[i] == blen[i]) begin
                    req[i] = 1'b0;
                    vin[i] = 1'b0;
                end else if (!silent[i] && ($urandom % 4) != 0) begin
                    vin[i] = 1'b1;
                    din[32*i +: 32] = (sent[i] == 0) ? cmd[i] : $urandom;
                    sent[i]++;
                end else begin
                    vin[i] = 1'b0;
                end
            end else if (got[i]) begin
                // grant was revoked under us: abandon the burst
                req[i] = 1'b0;
                vin[i] = 1'b0;
            end else begin
                vin[i] = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        logic [NREQ-1:0] eack;
        bit ev;
        eack = '0;
        if (mph == 1) eack[mg] = 1'b1;
        ev = (mph == 1) && vin[mg];
        chk("ack", 32'(ack), 32'(eack));
        chk("m_vout", 32'(m_vout), 32'(ev));
        chk("m_dout", m_dout, ev ? port_din(mg) : 32'h0);
        chk("m_sop", 32'(m_sop), 32'(ev && mfirst));
        chk("m_id", 32'(m_id), 32'(mg));
        chk("frm_done", 32'(frm_done), 32'(mfrm));
        chk("tmo_err", 32'(tmo_err), 32'(mtmo));
        chk("gnt_cnt", 32'(gnt_cnt), 32'(mcnt));
    endtask

    task automatic step();
        int idx;
        s_req = req; s_vin = vin; s_enb = enb; s_rst = rst;
        for (int i = 0; i < NREQ; i++) s_din[i] = port_din(i);
        @(posedge clk);
        #1;
        model_update();
        if (!rst) drive_inputs();
        if (prev_ack == '0 && ack != '0) begin
            idx = -1;
            for (int j = 0; j < NREQ; j++) if (ack[j]) idx = j;
            dq.push_back(idx);
        end
        prev_ack = ack;
        @(negedge clk);
        check_all();
        for (int i = 0; i < NREQ; i++) begin
            if (frm_done[i]) frm_seen[i]++;
            if (ack[i]) ack_hi[i]++;
        end
        if (m_sop) sop_seen++;
        if (m_vout) beat_seen++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr_stats();
        for (int i = 0; i < NREQ; i++) begin
            frm_seen[i] = 0;
            ack_hi[i] = 0;
        end
        sop_seen = 0;
        beat_seen = 0;
    endtask

    // Asynchronous reset between clock edges, possibly mid-burst
    task automatic do_reset();
        #2;
        rst = 1'b1;
        req = '0;
        vin = '0;
        for (int i = 0; i < NREQ; i++) got[i] = 0;
        model_reset();
        #1;
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_vout", 32'(m_vout), 32'h0);
        chk("rst_sop", 32'(m_sop), 32'h0);
        chk("rst_frm", 32'(frm_done), 32'h0);
        chk("rst_cnt", 32'(gnt_cnt), 32'h0);
        chk("rst_mid", 32'(m_id), 32'h0);
        steps(2);
        rst = 1'b0;
        dq.delete();
        prev_ack = '0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b1; enb = 1'b1; req = '0; vin = '0; din = '0;
        for (int i = 0; i < NREQ; i++) begin
            pct[i] = 0; got[i] = 0; sent[i] = 0; blen[i] = 0; silent[i] = 0; cmd[i] = '0;
        end
        sil_pct = 0; enb_pct = 8; blen_fix = 0; noise = 0;
        prev_ack = '0;
        model_reset();
        clr_stats();
        steps(2);
        chk("init_ack", 32'(ack), 32'h0);
        chk("init_dout", m_dout, 32'h0);
        chk("init_tmo", 32'(tmo_err), 32'h0);
        chk("init_cnt", 32'(gnt_cnt), 32'h0);
        rst = 1'b0;

        // Single port 0, 12 beats, not a last burst
        steps(10);
        clr_stats();
        raise(0, 12, 32'h0000_000B, 0);
        steps(30);
        chk("A_cnt", 32'(gnt_cnt), 32'd1);
        chk("A_frm0", 32'(frm_seen[0]), 32'd0);
        chk("A_sop", 32'(sop_seen), 32'd1);
        chk("A_beats", 32'(beat_seen), 32'd12);
        chk("A_id", 32'(qat(0)), 32'd0);

        // Port 3 alone, then ports 1 and 3 together: 1 goes first
        raise(3, 4, 32'h0000_0003, 0);
        steps(25);
        raise(1, 4, 32'h0000_0001, 0);
        raise(3, 4, 32'h0000_0003, 0);
        steps(40);
        chk("B_first", 32'(qat(2)), 32'd1);
        chk("B_second", 32'(qat(3)), 32'd3);

        // All ports hold requests continuously after a fresh reset
        do_reset();
        blen_fix = 2;
        for (int i = 0; i < NREQ; i++) pct[i] = 16;
        steps(60);
        for (int i = 0; i < NREQ; i++) pct[i] = 0;
        steps(40);
        blen_fix = 0;
        chk("C_g0", 32'(qat(0)), 32'd0);
        chk("C_g1", 32'(qat(1)), 32'd1);
        chk("C_g2", 32'(qat(2)), 32'd2);
        chk("C_g3", 32'(qat(3)), 32'd3);
        chk("C_g4", 32'(qat(4)), 32'd0);

        // Last-burst command on port 2
        clr_stats();
        raise(2, 8, 32'h0000_0207, 0);
        steps(30);
        chk("D_frm2", 32'(frm_seen[2]), 32'd1);

        // Port 1 acked but silent: revoked after TMO cycles, port 2 next
        clr_stats();
        raise(1, 4, 32'h0000_0201, 1);
        steps(5);
        raise(2, 3, 32'h0000_0002, 0);
        steps(300);
        chk("E_tmo", 32'(tmo_err), 32'd1);
        chk("E_frm1", 32'(frm_seen[1]), 32'd0);
        chk("E_ack1", 32'(ack_hi[1]), 32'd255);
        chk("E_prev", 32'(qat(dq.size() - 2)), 32'd1);
        chk("E_next", 32'(qat(dq.size() - 1)), 32'd2);

        // Random traffic with enable toggling and stray beats on idle ports
        noise = 1; sil_pct = 1; enb_pct = 6;
        for (int i = 0; i < NREQ; i++) pct[i] = 1 + int'($urandom % 5);
        steps(6000);
        for (int i = 0; i < NREQ; i++) pct[i] = 0;
        noise = 0; sil_pct = 0; enb_pct = 8;
        steps(300);

        // Reset in the middle of a port 0 burst
        raise(0, 12, 32'h0000_0000, 0);
        steps(5);
        chk("G_pre", 32'(ack[0]), 32'd1);
        do_reset();
        raise(0, 3, 32'h0000_0000, 0);
        raise(1, 3, 32'h0000_0001, 0);
        steps(40);
        chk("G_first", 32'(qat(0)), 32'd0);
        chk("G_second", 32'(qat(1)), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dwr_arb.md
# dwr_arb

Round-robin arbiter that shares the single DDR write channel among up to NREQ burst writers (GFTT output buffer, other DVP output buffers). Each requester speaks the dwr_req/dwr_ack/dwr_vout/dwr_dout protocol. The arbiter grants one requester at a time and holds the grant for the whole burst. It forwards the granted beat stream with SOP and port-ID sideband to the DDR write engine. It also reports per-port frame completion and stall errors.

## Interface
- NREQ, 4: number of requester ports (2..8)
- TMO, 255: max cycles a granted requester may stay silent before the grant is revoked
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset; asynchronous, active-high
- enb  in  1  arbiter enable; low blocks new grants
- req  in  NREQ  dwr_req from each requester
- ack  out  NREQ  dwr_ack to each requester; one-hot or zero
- vin  in  NREQ  dwr_vout from each requester
- din  in  32*NREQ  dwr_dout from each requester; port i at bits [32i+31:32i]
- m_vout  out  1  beat valid to DDR write engine
- m_dout  out  32  beat data
- m_sop  out  1  first beat of a grant (command word)
- m_id  out  3  index of granted port
- frm_done  out  NREQ  1-cycle pulse: a burst whose command bit 9 (last burst) was set has completed
- tmo_err  out  1  sticky; grant revoked by timeout
- gnt_cnt  out  16  grants issued since reset; wraps

## Operation
- FSM states: IDLE, GRANT, RELEASE.
- IDLE: if enb and any req bit is set, pick the first set bit searching upward from ptr+1 (modulo NREQ). Register gnt_id. Set ack[gnt_id]. Go to GRANT.
- GRANT: ack[gnt_id] stays high.
  - If req[gnt_id]=0, clear ack and go to RELEASE.
  - If the silence counter reaches TMO, clear ack, set tmo_err and go to RELEASE.
- RELEASE: one cycle. Set ptr = gnt_id. Increment gnt_cnt. Go to IDLE.
- Silence counter: 8-bit. Clears on any granted beat and on grant entry. Increments in GRANT while vin[gnt_id]=0 and req[gnt_id]=1.
- Beat forwarding:
  - m_vout = vin[gnt_id] & ack[gnt_id] & (state==GRANT).
  - m_dout = din[gnt_id] when m_vout=1, else 0.
  - m_id = gnt_id.
- First-beat handling: the first forwarded beat of a grant raises m_sop. Bit 9 of that beat is latched as last_flg.
- frm_done[gnt_id] pulses in RELEASE when last_flg=1 and the release was not a timeout.
- Beats on vin of non-granted ports are ignored. Requesters only drive beats while acked.
- enb low: no new grant; an in-progress grant completes normally.
- Reset mid-burst: ack, m_vout, m_sop and frm_done go low asynchronously. FSM goes to IDLE and ptr=NREQ-1, so port 0 wins first.

## Timing
- Reset values:
  - ack=0, m_vout=0, m_dout=0, m_sop=0, m_id=0
  - frm_done=0, tmo_err=0, gnt_cnt=0
  - state=IDLE, ptr=NREQ-1
- ack is registered: req sampled high in IDLE at edge t gives ack high after t.
- Release timing: req sampled low in GRANT at edge t gives ack low after t. RELEASE runs for cycle t+1, and the earliest next ack is after t+2.
- Minimum two-cycle gap between grants.
- m_vout/m_dout/m_sop/m_id are combinational from registered state and requester outputs. Zero-cycle forwarding latency.
- Simultaneous requests: ports never starve. A held request is granted within NREQ-1 other grants.
- Single active requester: re-granted every time it re-requests, with no penalty beyond the two-cycle gap.
- gnt_cnt wraps 0xFFFF to 0x0000.

## Structure
- Package dvp_pkg:
  - FSM state encoding (IDLE=0, GRANT=1, RELEASE=2)
  - DWR_CMD_LAST_BIT=9
  - DWR_CMD_LEN_MSB=7
- One sub-module, rr_pick: combinational round-robin selector. Inputs req vector and ptr; outputs index and valid.

## Test plan
- Single port 0: req rises at cycle 10; 12 beats, the first with bit 9=0. Expect ack[0] high at cycle 11, m_sop only on the first beat, m_id=0, all 12 beats forwarded in order, gnt_cnt=1, no frm_done.
- Ports 1 and 3 request together; ptr=3 after a prior port-3 grant. Expect port 1 granted first, then port 3 after the two-cycle gap. No beat interleaving.
- All four ports hold req continuously. Expect grant order 0,1,2,3,0 and gnt_cnt=5 after five releases.
- Port 2 command word 0x0000_0207 (last set, len_m1=7). Expect one frm_done[2] pulse in the cycle after req[2] falls.
- Port 1 acked but never drives vin, with TMO=255. Expect ack[1] dropped on the 255th silent cycle, tmo_err=1 sticky, no frm_done, next port granted afterwards.
- rst pulsed mid-burst on port 0:
  - Expect ack=0 and m_vout=0 immediately, and state=IDLE.
  - Expect port 0 granted first after rst release when ports 0 and 1 both request.
